// File: rtl/serial_subtractor_pkg.sv
// Shared types for the bit-serial subtractor: FSM state encoding and the
// signed-overflow rule used when SERIAL_SUB_OVF_EN is defined.
// Pure declarations, no logic or latency.
package serial_subtractor_pkg;

    // IDLE waits for start, RUN consumes one bit per clock, DONE publishes.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // a - b overflows only when the operand signs differ and the result sign
    // differs from the minuend sign.
    function automatic logic sub_ovf(input logic a_msb, input logic b_msb,
                                     input logic d_msb);
        return (a_msb != b_msb) && (d_msb != a_msb);
    endfunction

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell: d = a - b - bin, bout = borrow out.
// Latency: purely combinational.
// Backpressure: none; a leaf cell with no handshake.
module full_subtractor
    import serial_subtractor_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic bout,
    output logic d
);

    // Difference bit is the same parity function as the adder's sum.
    assign d    = a ^ b ^ bin;

    // Borrow when b exceeds a, or when they match and a borrow arrives.
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a - b, LSB first, through one registered borrow; optional ovf output (SERIAL_SUB_OVF_EN).
// Latency: done pulses WIDTH+1 cycles after start is accepted; one result per WIDTH+2 cycles.
// Backpressure: start is only sampled in IDLE; it is ignored in RUN and DONE.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = 8    // legal range 2..32
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = $clog2(WIDTH);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [WIDTH-1:0] d_sr_q, d_sr_d;
    logic             bin_q, bin_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_q, borrow_d;
`ifdef SERIAL_SUB_OVF_EN
    logic             a_msb_q, a_msb_d;
    logic             b_msb_q, b_msb_d;
    logic             ovf_q, ovf_d;
`endif

    logic             bit_d;
    logic             bit_bout;

    // The single arithmetic cell always looks at bit 0 of both operand shifters.
    full_subtractor u_fsub (
        .a    (a_sr_q[0]),
        .b    (b_sr_q[0]),
        .bin  (bin_q),
        .bout (bit_bout),
        .d    (bit_d)
    );

    // Next-state, datapath shifting and result capture.
    always_comb begin
        state_d  = state_q;
        a_sr_d   = a_sr_q;
        b_sr_d   = b_sr_q;
        d_sr_d   = d_sr_q;
        bin_d    = bin_q;
        cnt_d    = cnt_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
`ifdef SERIAL_SUB_OVF_EN
        a_msb_d  = a_msb_q;
        b_msb_d  = b_msb_q;
        ovf_d    = ovf_q;
`endif
        // busy/done trail the state by one register stage so the published
        // result and its flags change on the same edge.
        busy_d   = (state_q != ST_IDLE);
        done_d   = (state_q == ST_DONE);

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d  = ST_RUN;
                    a_sr_d   = a;
                    b_sr_d   = b;
                    d_sr_d   = '0;
                    bin_d    = 1'b0;
                    cnt_d    = '0;
                    diff_d   = '0;
                    borrow_d = 1'b0;
`ifdef SERIAL_SUB_OVF_EN
                    a_msb_d  = a[WIDTH-1];
                    b_msb_d  = b[WIDTH-1];
                    ovf_d    = 1'b0;
`endif
                end
            end
            ST_RUN: begin
                a_sr_d = a_sr_q >> 1;
                b_sr_d = b_sr_q >> 1;
                d_sr_d = {bit_d, d_sr_q[WIDTH-1:1]};
                bin_d  = bit_bout;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = ST_DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q + CW'(1);
                end
            end
            ST_DONE: begin
                state_d  = ST_IDLE;
                diff_d   = d_sr_q;
                borrow_d = bin_q;
`ifdef SERIAL_SUB_OVF_EN
                ovf_d    = sub_ovf(a_msb_q, b_msb_q, d_sr_q[WIDTH-1]);
`endif
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            d_sr_q   <= '0;
            bin_q    <= 1'b0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            a_msb_q  <= 1'b0;
            b_msb_q  <= 1'b0;
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            a_sr_q   <= a_sr_d;
            b_sr_q   <= b_sr_d;
            d_sr_q   <= d_sr_d;
            bin_q    <= bin_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
`ifdef SERIAL_SUB_OVF_EN
            a_msb_q  <= a_msb_d;
            b_msb_q  <= b_msb_d;
            ovf_q    <= ovf_d;
`endif
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign diff   = diff_q;
    assign borrow = borrow_q;
`ifdef SERIAL_SUB_OVF_EN
    assign ovf    = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor (WIDTH=8) and its full_subtractor cell.
// Inputs change and outputs are sampled on the falling edge.
// ovf checks are compiled in only with SERIAL_SUB_OVF_EN.
module tb_serial_subtractor;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] a_s;
    logic [7:0] b_s;
    logic       busy;
    logic       done;
    logic [7:0] diff;
    logic       borrow;
`ifdef SERIAL_SUB_OVF_EN
    logic       ovf;
`endif

    logic       fs_a, fs_b, fs_bin, fs_bout, fs_d;

    int n_cmp;
    int n_err;
    logic last_ovf;

    serial_subtractor #(.WIDTH(8)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .a      (a_s),
        .b      (b_s),
        .busy   (busy),
        .done   (done),
        .diff   (diff),
        .borrow (borrow)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .ovf    (ovf)
`endif
    );

    full_subtractor u_cell (
        .a    (fs_a),
        .b    (fs_b),
        .bin  (fs_bin),
        .bout (fs_bout),
        .d    (fs_d)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Launch one operation with a single-cycle start and watch it to completion.
    task automatic run_op(input logic [7:0] va, input logic [7:0] vb,
                          input logic [7:0] ed, input logic eb, input string tag);
        int         done_cnt;
        int         busy_cnt;
        int         done_at;
        logic [7:0] got_d;
        logic       got_b;
        done_cnt = 0;
        busy_cnt = 0;
        done_at  = -1;
        got_d    = 8'h00;
        got_b    = 1'b0;
        @(negedge clk);
        a_s   = va;
        b_s   = vb;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        // Iteration i samples the cycle between edges E0+i and E0+i+1.
        for (int i = 0; i < 14; i++) begin
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                done_at = i;
                got_d   = diff;
                got_b   = borrow;
`ifdef SERIAL_SUB_OVF_EN
                last_ovf = ovf;
`endif
            end
            @(negedge clk);
        end
        check({tag, "_done_cnt"}, done_cnt, 1);
        check({tag, "_done_lat"}, done_at, 9);
        check({tag, "_busy_cyc"}, busy_cnt, 9);
        check({tag, "_diff"}, {24'd0, got_d}, {24'd0, ed});
        check({tag, "_borrow"}, {31'd0, got_b}, {31'd0, eb});
        check({tag, "_diff_hold"}, {24'd0, diff}, {24'd0, ed});
    endtask

    initial begin
        logic [1:0] fs_exp [8];
        int         done_cnt;
        int         busy_cnt;
        int         done_idx [$];
        logic [7:0] done_val [$];

        n_cmp    = 0;
        n_err    = 0;
        last_ovf = 1'b0;
        rst      = 1'b1;
        start    = 1'b0;
        a_s      = 8'h00;
        b_s      = 8'h00;
        fs_a     = 1'b0;
        fs_b     = 1'b0;
        fs_bin   = 1'b0;

        // Full-subtractor truth table, index {a,b,bin}, value {d,bout}.
        fs_exp = '{2'b00, 2'b11, 2'b11, 2'b01, 2'b10, 2'b00, 2'b00, 2'b11};
        for (int i = 0; i < 8; i++) begin
            fs_a   = i[2];
            fs_b   = i[1];
            fs_bin = i[0];
            #1;
            check($sformatf("fsub_%0d%0d%0d", i[2], i[1], i[0]),
                  {30'd0, fs_d, fs_bout}, {30'd0, fs_exp[i]});
        end

        // Reset values.
        repeat (2) @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_diff", {24'd0, diff}, 32'd0);
        check("rst_borrow", {31'd0, borrow}, 32'd0);
`ifdef SERIAL_SUB_OVF_EN
        check("rst_ovf", {31'd0, ovf}, 32'd0);
`endif

        // Reset and start together: reset wins, nothing launches.
        a_s   = 8'h01;
        start = 1'b1;
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check("rst_start_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        check("rst_start_busy2", {31'd0, busy}, 32'd0);

        // Main function.
        run_op(8'd10, 8'd3, 8'd7, 1'b0, "sub_10_3");
        run_op(8'd3, 8'd10, 8'hF9, 1'b1, "sub_3_10");
        run_op(8'hFF, 8'hFF, 8'h00, 1'b0, "sub_ff_ff");
        run_op(8'h00, 8'h01, 8'hFF, 1'b1, "sub_0_1");
        run_op(8'h80, 8'h01, 8'h7F, 1'b0, "sub_80_01");
`ifdef SERIAL_SUB_OVF_EN
        check("ovf_80_01", {31'd0, last_ovf}, 32'd1);
`endif
        run_op(8'h05, 8'h03, 8'h02, 1'b0, "sub_05_03");
`ifdef SERIAL_SUB_OVF_EN
        check("ovf_05_03", {31'd0, last_ovf}, 32'd0);
`endif

        // start pulsed during RUN with new operands is ignored.
        @(negedge clk);
        a_s   = 8'd10;
        b_s   = 8'd3;
        start = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        done_cnt = 0;
        for (int i = 0; i < 14; i++) begin
            if (i == 3) begin
                a_s   = 8'd1;
                b_s   = 8'd1;
                start = 1'b1;
            end
            if (i == 4) start = 1'b0;
            if (done) begin
                done_cnt++;
                check("midrun_diff", {24'd0, diff}, 32'd7);
            end
            @(negedge clk);
        end
        check("midrun_done_cnt", done_cnt, 1);

        // Reset four cycles into RUN abandons the operation.
        a_s   = 8'd10;
        b_s   = 8'd3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        check("pre_rst_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_diff", {24'd0, diff}, 32'd0);
        done_cnt = 0;
        busy_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            if (done) done_cnt++;
            if (busy) busy_cnt++;
            @(negedge clk);
        end
        check("midrst_no_done", done_cnt, 0);
        check("midrst_no_busy", busy_cnt, 0);
        run_op(8'd20, 8'd5, 8'd15, 1'b0, "after_rst");

        // start held high relaunches every WIDTH+2 cycles.
        a_s   = 8'd10;
        b_s   = 8'd3;
        start = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 25; i++) begin
            if (done) begin
                done_idx.push_back(i);
                done_val.push_back(diff);
            end
            @(negedge clk);
        end
        start = 1'b0;
        repeat (14) @(negedge clk);
        check("b2b_count", done_idx.size(), 2);
        if (done_idx.size() >= 2) begin
            check("b2b_first", done_idx[0], 9);
            check("b2b_period", done_idx[1] - done_idx[0], 10);
            check("b2b_diff0", {24'd0, done_val[0]}, 32'd7);
            check("b2b_diff1", {24'd0, done_val[1]}, 32'd7);
        end
        check("final_busy", {31'd0, busy}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
